frontend_traffic_checker: RTL and testbench
===========================================

Name: frontend_traffic_checker

Overview:
- Synthesizable, parametrised successor to the bank-level bench's stimulus and check process.
- Issues frontend commands over a programmable row/column window with strides, in write-then-read or interleaved mode.
- Throttles backend_controller_ren and checks in-order read data against a deterministic address-derived pattern.
- Sits in front of the backend controller; drives its command/valid inputs and consumes read_data/read_data_valid.

Parameters:
- ROW_W, 16, row address width
- COL_W, 4, column address width
- DATA_W, 1024, data word width (DQ_BITS*8)
- CMD_W, FRONTEND_CMD_BITS, packed command width
- CNT_W, 32, width of error, latency and read counters
- TIMEOUT, 4096, cycles without read_data_valid in DRAIN before abort

Ports:
- clk  in  1  system clock
- power_on_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- cfg_mode  in  1  0 = all writes then all reads; 1 = interleaved W,R per address
- cfg_row_begin  in  ROW_W  first row, inclusive
- cfg_row_end  in  ROW_W+1  last row, exclusive
- cfg_row_stride  in  ROW_W  row step, must be >=1
- cfg_col_stride  in  COL_W  column step, must be >=1
- cfg_seed  in  DATA_W  XOR mask applied to pattern
- cfg_ren_period  in  16  0 = ren held 1; N>0 = ren toggles every N+1 cycles
- command  out  CMD_W  frontend_command_t {op_type, data_type, row_addr, col_addr}
- valid  out  1  command valid
- write_data  out  DATA_W  write payload; qualified by valid and OP_WRITE
- ba_cmd_pm  in  1  backend ready
- backend_controller_ren  out  1  read-return enable to backend
- read_data  in  DATA_W  returned data
- read_data_valid  in  1  read_data qualifier
- done  out  1  run finished (level)
- timeout  out  1  run aborted by TIMEOUT
- error_count  out  CNT_W  mismatching reads
- read_count  out  CNT_W  reads received
- latency  out  CNT_W  cycles from first handshake to last read
- first_err_row  out  ROW_W  row of first mismatch
- first_err_col  out  COL_W  column of first mismatch

Behaviour:
- Reset value of every output and counter is 0. In reset, backend_controller_ren = 0.
- Pattern: exp(r,c) = zero_extend(r*2^COL_W + c) XOR cfg_seed, truncated to DATA_W.
- data_type is always DATA_TYPE_WEIGHTS.
- Handshake:
  - Transfer when valid && ba_cmd_pm at posedge clk.
  - While valid && !ba_cmd_pm, command and write_data hold stable.
  - valid never drops without a transfer, except on reset.
- Address generator:
  - Column starts at 0 and advances by cfg_col_stride.
  - When col + stride >= 2^COL_W, column goes to 0 and row advances by cfg_row_stride.
  - Last address: next row >= cfg_row_end. Overflow is computed in ROW_W+1 bits.
  - N_ADDR = ceil((end-begin)/rstride) * ceil(2^COL_W/cstride).
- FSM:
  - IDLE: on start, latch cfg, clear all counters, done, timeout and first_err. Go to WRITE.
  - WRITE (mode 0): issue OP_WRITE with exp data per address. After the last transfer, reset the generator and go to READ.
  - READ (mode 0): issue OP_READ per address, write_data = 0. After the last transfer go to DRAIN.
  - WRITE/READ (mode 1): alternate OP_WRITE then OP_READ at the same address. Advance the address after the read transfer. After the last read go to DRAIN.
  - DRAIN: valid = 0. When read_count == N_ADDR, go to DONE. If TIMEOUT cycles pass with no read_data_valid, set timeout and go to DONE.
  - DONE: done = 1, outputs hold. start returns to IDLE behaviour for a new run.
  - cfg_row_begin >= cfg_row_end: start goes directly to DONE with counters 0.
- Checker:
  - Read returns are in issue order.
  - A separate check address generator advances on each read_data_valid, which counts only when backend_controller_ren = 1.
  - Mismatch (4-state compare in sim, == in synthesis) increments error_count.
  - The first mismatch latches first_err_row/col.
  - read_data_valid in IDLE/DONE is ignored.
  - Reads arriving during WRITE/READ in mode 1 are checked immediately.
- Ren throttle:
  - Counter counts 0..cfg_ren_period, then wraps and toggles ren.
  - Ren is 1 in IDLE when period = 0.
  - Throttle runs in all states after reset.
- Latency:
  - Starts counting on the cycle after the first handshake of the run.
  - Stops when read_count reaches N_ADDR.
  - Saturates at all-ones.
  - error_count and read_count saturate.
- start while busy is ignored.
- Reset mid-run aborts immediately: outputs go to 0 and the FSM goes to IDLE.

Test Plan:
- Mode 0, rows 0..16, strides 1, seed 0, period 0, ba_cmd_pm = 1, ideal echo memory -> 256 writes then 256 reads; read_count = 256, error_count = 0, done = 1.
- ba_cmd_pm random 50% -> command/write_data stable during stall; each address issued exactly once; error_count = 0.
- Memory corrupts row 5 col 3 (bit 0 flipped) -> error_count = 1, first_err_row = 5, first_err_col = 3.
- Mode 1, rows 2..6 step 2, col stride 4, seed 0xA5 -> command sequence W(2,0),R(2,0),W(2,4),… ending R(4,12); 8 reads, error_count = 0.
- cfg_ren_period = 15 -> ren toggles every 16 cycles; valid returns with ren = 0 are not counted; run still completes via repeated returns.
- Backend drops the final read -> timeout = 1 after 4096 cycles, read_count = N_ADDR−1; then reset mid-run in WRITE -> all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/frontend_traffic_checker.sv
`timescale 1ns/1ps
// Strided write/read traffic generator with in-order read-data checker and ren throttle.
// command layout: {op_type[1:0], data_type[1:0], row_addr[ROW_W-1:0], col_addr[COL_W-1:0]}.
module frontend_traffic_checker #(
  parameter int ROW_W   = 16,
  parameter int COL_W   = 4,
  parameter int DATA_W  = 1024,
  parameter int CMD_W   = 4 + ROW_W + COL_W,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              power_on_rst_n,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic [ROW_W-1:0]  cfg_row_begin,
  input  logic [ROW_W:0]    cfg_row_end,
  input  logic [ROW_W-1:0]  cfg_row_stride,
  input  logic [COL_W-1:0]  cfg_col_stride,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [15:0]       cfg_ren_period,
  output logic [CMD_W-1:0]  command,
  output logic              valid,
  output logic [DATA_W-1:0] write_data,
  input  logic              ba_cmd_pm,
  output logic              backend_controller_ren,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  error_count,
  output logic [CNT_W-1:0]  read_count,
  output logic [CNT_W-1:0]  latency,
  output logic [ROW_W-1:0]  first_err_row,
  output logic [COL_W-1:0]  first_err_col
);
  localparam logic [1:0] OP_READ = 2'd1, OP_WRITE = 2'd2, DATA_TYPE_WEIGHTS = 2'd1;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [1:0]       op_type;
    logic [1:0]       data_type;
    logic [ROW_W-1:0] row_addr;
    logic [COL_W-1:0] col_addr;
  } frontend_command_t;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  function automatic void addr_step(
    input  logic [ROW_W-1:0] row,     input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] rstride, input  logic [COL_W-1:0] cstride,
    input  logic [ROW_W:0]   row_end,
    output logic [ROW_W-1:0] nrow,    output logic [COL_W-1:0] ncol,
    output logic             last);
    logic [COL_W:0] csum;
    logic [ROW_W:0] rsum;
    csum = {1'b0, col} + {1'b0, cstride};
    rsum = {1'b0, row} + {1'b0, rstride};
    nrow = row;
    ncol = csum[COL_W-1:0];
    last = 1'b0;
    if (csum[COL_W]) begin
      ncol = '0;
      nrow = rsum[ROW_W-1:0];
      last = (rsum >= row_end);
    end
  endfunction

  function automatic logic [DATA_W-1:0] pattern(
    input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col, input logic [DATA_W-1:0] seed);
    return DATA_W'({row, col}) ^ seed;
  endfunction

  state_t state_q, state_d;
  logic              mode_q, mode_d;
  logic [ROW_W-1:0]  row_begin_q, row_begin_d, rstride_q, rstride_d;
  logic [ROW_W:0]    row_end_q, row_end_d;
  logic [COL_W-1:0]  cstride_q, cstride_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ROW_W-1:0]  row_q, row_d, chk_row_q, chk_row_d, first_row_q, first_row_d;
  logic [COL_W-1:0]  col_q, col_d, chk_col_q, chk_col_d, first_col_q, first_col_d;
  logic              chk_done_q, chk_done_d, err_seen_q, err_seen_d, lat_run_q, lat_run_d;
  logic              timeout_q, timeout_d, ren_q, ren_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d, rd_cnt_q, rd_cnt_d, lat_q, lat_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]       ren_cnt_q, ren_cnt_d;

  logic [ROW_W-1:0]  gen_nrow, chk_nrow;
  logic [COL_W-1:0]  gen_ncol, chk_ncol;
  logic              gen_last, chk_last;
  frontend_command_t cmd;
  logic              fire, start_ok, run_state, rd_take, to_expire, empty_cfg;

  always_comb addr_step(row_q, col_q, rstride_q, cstride_q, row_end_q, gen_nrow, gen_ncol, gen_last);
  always_comb addr_step(chk_row_q, chk_col_q, rstride_q, cstride_q, row_end_q, chk_nrow, chk_ncol, chk_last);

  assign fire      = valid && ba_cmd_pm;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign empty_cfg = ({1'b0, cfg_row_begin} >= cfg_row_end);
  assign run_state = (state_q == S_WRITE || state_q == S_READ || state_q == S_DRAIN);
  assign rd_take   = read_data_valid && ren_q && run_state && !chk_done_q;
  assign to_expire = (state_q == S_DRAIN) && !read_data_valid && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = empty_cfg ? S_DONE : S_WRITE;
      S_WRITE: if (fire && (mode_q || gen_last)) state_d = S_READ;
      S_READ: begin
        if (fire) begin
          if (gen_last)    state_d = S_DRAIN;
          else if (mode_q) state_d = S_WRITE;
        end
      end
      S_DRAIN: if (chk_done_q || to_expire) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd        = '0;
    valid      = 1'b0;
    write_data = '0;
    done       = (state_q == S_DONE);
    if (state_q == S_WRITE || state_q == S_READ) begin
      valid         = 1'b1;
      cmd.op_type   = (state_q == S_WRITE) ? OP_WRITE : OP_READ;
      cmd.data_type = DATA_TYPE_WEIGHTS;
      cmd.row_addr  = row_q;
      cmd.col_addr  = col_q;
      if (state_q == S_WRITE) write_data = pattern(row_q, col_q, seed_q);
    end
  end

  always_comb begin
    mode_d = mode_q; row_begin_d = row_begin_q; row_end_d = row_end_q;
    rstride_d = rstride_q; cstride_d = cstride_q; seed_d = seed_q;
    row_d = row_q; col_d = col_q; chk_row_d = chk_row_q; chk_col_d = chk_col_q;
    chk_done_d = chk_done_q; err_seen_d = err_seen_q; lat_run_d = lat_run_q;
    first_row_d = first_row_q; first_col_d = first_col_q; timeout_d = timeout_q;
    err_cnt_d = err_cnt_q; rd_cnt_d = rd_cnt_q; lat_d = lat_q; to_cnt_d = to_cnt_q;
    if (start_ok) begin
      mode_d = cfg_mode; row_begin_d = cfg_row_begin; row_end_d = cfg_row_end;
      rstride_d = cfg_row_stride; cstride_d = cfg_col_stride; seed_d = cfg_seed;
      row_d = cfg_row_begin; col_d = '0; chk_row_d = cfg_row_begin; chk_col_d = '0;
      chk_done_d = 1'b0; err_seen_d = 1'b0; lat_run_d = 1'b0; timeout_d = 1'b0;
      first_row_d = '0; first_col_d = '0; err_cnt_d = '0; rd_cnt_d = '0; lat_d = '0;
      to_cnt_d = '0;
    end else begin
      // mode 1 holds the address across the write so the read hits the same location
      if (fire && (!mode_q || state_q == S_READ)) begin
        if (gen_last && state_q == S_WRITE) begin
          row_d = row_begin_q;
          col_d = '0;
        end else begin
          row_d = gen_nrow;
          col_d = gen_ncol;
        end
      end
      if (fire) lat_run_d = 1'b1;
      if (lat_run_q && !chk_done_q && run_state && lat_q != '1) lat_d = lat_q + CNT_W'(1);
      if (rd_take) begin
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (read_data !== pattern(chk_row_q, chk_col_q, seed_q)) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (!err_seen_q) begin
            err_seen_d  = 1'b1;
            first_row_d = chk_row_q;
            first_col_d = chk_col_q;
          end
        end
        if (chk_last) chk_done_d = 1'b1;
        chk_row_d = chk_nrow;
        chk_col_d = chk_ncol;
      end
      if (state_q == S_DRAIN && !read_data_valid) to_cnt_d = to_cnt_q + TO_W'(1);
      else                                          to_cnt_d = '0;
      if (to_expire && !chk_done_q) timeout_d = 1'b1;
    end
  end

  // free-running throttle; period 0 means ren permanently enabled
  always_comb begin
    ren_d     = ren_q;
    ren_cnt_d = ren_cnt_q + 16'd1;
    if (cfg_ren_period == 16'd0) begin
      ren_d     = 1'b1;
      ren_cnt_d = '0;
    end else if (ren_cnt_q >= cfg_ren_period) begin
      ren_d     = !ren_q;
      ren_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      mode_q <= 1'b0; row_begin_q <= '0; row_end_q <= '0; rstride_q <= '0; cstride_q <= '0;
      seed_q <= '0; row_q <= '0; col_q <= '0; chk_row_q <= '0; chk_col_q <= '0;
      chk_done_q <= 1'b0; err_seen_q <= 1'b0; lat_run_q <= 1'b0; timeout_q <= 1'b0;
      first_row_q <= '0; first_col_q <= '0; err_cnt_q <= '0; rd_cnt_q <= '0; lat_q <= '0;
      to_cnt_q <= '0; ren_q <= 1'b0; ren_cnt_q <= '0;
    end else begin
      mode_q <= mode_d; row_begin_q <= row_begin_d; row_end_q <= row_end_d;
      rstride_q <= rstride_d; cstride_q <= cstride_d; seed_q <= seed_d;
      row_q <= row_d; col_q <= col_d; chk_row_q <= chk_row_d; chk_col_q <= chk_col_d;
      chk_done_q <= chk_done_d; err_seen_q <= err_seen_d; lat_run_q <= lat_run_d;
      timeout_q <= timeout_d; first_row_q <= first_row_d; first_col_q <= first_col_d;
      err_cnt_q <= err_cnt_d; rd_cnt_q <= rd_cnt_d; lat_q <= lat_d; to_cnt_q <= to_cnt_d;
      ren_q <= ren_d; ren_cnt_q <= ren_cnt_d;
    end
  end

  assign command                = CMD_W'(cmd);
  assign backend_controller_ren = ren_q;
  assign timeout                = timeout_q;
  assign error_count            = err_cnt_q;
  assign read_count             = rd_cnt_q;
  assign latency                = lat_q;
  assign first_err_row          = first_row_q;
  assign first_err_col          = first_col_q;
endmodule

// File: tb/tb_frontend_traffic_checker.sv
`timescale 1ns/1ps
// Bench: table of run configurations against an echo-memory backend with a command scoreboard.
module tb_frontend_traffic_checker;
  localparam int ROW_W = 16, COL_W = 4, DATA_W = 1024, CMD_W = 24, CNT_W = 32, TIMEOUT = 4096;
  localparam logic [1:0] OP_READ = 2'd1, OP_WRITE = 2'd2, DT_WEIGHTS = 2'd1;

  logic clk, power_on_rst_n, start, cfg_mode, valid, ba_cmd_pm, backend_controller_ren;
  logic read_data_valid, done, timeout;
  logic [ROW_W-1:0]  cfg_row_begin, cfg_row_stride, first_err_row;
  logic [ROW_W:0]    cfg_row_end;
  logic [COL_W-1:0]  cfg_col_stride, first_err_col;
  logic [DATA_W-1:0] cfg_seed, write_data, read_data;
  logic [15:0]       cfg_ren_period;
  logic [CMD_W-1:0]  command;
  logic [CNT_W-1:0]  error_count, read_count, latency;

  frontend_traffic_checker dut (
    .clk(clk), .power_on_rst_n(power_on_rst_n), .start(start), .cfg_mode(cfg_mode),
    .cfg_row_begin(cfg_row_begin), .cfg_row_end(cfg_row_end), .cfg_row_stride(cfg_row_stride),
    .cfg_col_stride(cfg_col_stride), .cfg_seed(cfg_seed), .cfg_ren_period(cfg_ren_period),
    .command(command), .valid(valid), .write_data(write_data), .ba_cmd_pm(ba_cmd_pm),
    .backend_controller_ren(backend_controller_ren), .read_data(read_data),
    .read_data_valid(read_data_valid), .done(done), .timeout(timeout),
    .error_count(error_count), .read_count(read_count), .latency(latency),
    .first_err_row(first_err_row), .first_err_col(first_err_col));

  typedef struct {
    bit mode; int rbeg; int rend; int rstr; int cstr; logic [31:0] seed; int period; int stall;
    bit corrupt; bit drop; bit busy_start; int exp_reads; int exp_errs; bit exp_to;
    int exp_frow; int exp_fcol;
  } vec_t;
  typedef struct { logic [CMD_W-1:0] cmd; logic [DATA_W-1:0] wd; } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  int   ret_q[$];
  logic [DATA_W-1:0] mem [int];

  int errors = 0, checks = 0, cyc = 0, stall_pct = 0, n_exp = 0, reads_issued = 0;
  int first_xfer_cyc = -1, last_read_cyc = -1;
  bit corrupt = 0, drop = 0, stall_pending = 0;
  logic [CMD_W-1:0]  prev_cmd;
  logic [DATA_W-1:0] prev_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] op, input int key);
    return {op, DT_WEIGHTS, 16'(key >> 4), 4'(key & 15)};
  endfunction

  task automatic build_expected(input vec_t v);
    int addrs[$];
    sb_t e;
    for (int r = v.rbeg; r < v.rend; r += v.rstr)
      for (int c = 0; c < 16; c += v.cstr) addrs.push_back(r * 16 + c);
    n_exp = addrs.size();
    if (v.mode) begin
      foreach (addrs[i]) begin
        e.cmd = mk_cmd(OP_WRITE, addrs[i]); e.wd = DATA_W'(addrs[i]) ^ cfg_seed; sb_q.push_back(e);
        e.cmd = mk_cmd(OP_READ, addrs[i]);  e.wd = '0;                          sb_q.push_back(e);
      end
    end else begin
      foreach (addrs[i]) begin
        e.cmd = mk_cmd(OP_WRITE, addrs[i]); e.wd = DATA_W'(addrs[i]) ^ cfg_seed; sb_q.push_back(e);
      end
      foreach (addrs[i]) begin
        e.cmd = mk_cmd(OP_READ, addrs[i]); e.wd = '0; sb_q.push_back(e);
      end
    end
  endtask

  // Backend model: drives ready/returns at negedge, then observes what the next posedge will transfer.
  always @(negedge clk) begin
    sb_t e;
    int key;
    cyc++;
    if (!power_on_rst_n) begin
      ba_cmd_pm = 1'b0; read_data_valid = 1'b0; read_data = '0; stall_pending = 0;
    end else begin
      ba_cmd_pm = (stall_pct == 0) || (int'($urandom_range(99)) >= stall_pct);
      if (ret_q.size() > 0) begin
        key = ret_q[0];
        read_data_valid = 1'b1;
        read_data = mem.exists(key) ? mem[key] : '0;
        if (corrupt && key == 5 * 16 + 3) read_data[0] = ~read_data[0];
      end else begin
        read_data_valid = 1'b0;
        read_data = '0;
      end
      #1;
      if (stall_pending)
        chk(valid && command == prev_cmd && write_data == prev_wd, "stall_hold", 64'(command), 64'(prev_cmd));
      stall_pending = valid && !ba_cmd_pm;
      prev_cmd = command;
      prev_wd  = write_data;
      if (valid && ba_cmd_pm) begin
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        key = int'(command[ROW_W+COL_W-1:0]);
        if (sb_q.size() == 0) chk(1'b0, "extra_cmd", 64'(command), 64'(0));
        else begin
          e = sb_q.pop_front();
          chk(command == e.cmd, "cmd", 64'(command), 64'(e.cmd));
          chk(write_data == e.wd, "wdata", write_data[63:0], e.wd[63:0]);
        end
        if (command[CMD_W-1 -: 2] == OP_WRITE) mem[key] = write_data;
        else begin
          if (!(drop && reads_issued == n_exp - 1)) ret_q.push_back(key);
          reads_issued++;
        end
      end
      if (read_data_valid && backend_controller_ren) begin
        void'(ret_q.pop_front());
        last_read_cyc = cyc;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int t, done_cyc, exp_lat;
    cfg_mode = v.mode; cfg_row_begin = 16'(v.rbeg); cfg_row_end = 17'(v.rend);
    cfg_row_stride = 16'(v.rstr); cfg_col_stride = 4'(v.cstr); cfg_ren_period = 16'(v.period);
    cfg_seed = DATA_W'(v.seed) | (DATA_W'(v.seed) << (DATA_W - 32));
    stall_pct = v.stall; corrupt = v.corrupt; drop = v.drop; reads_issued = 0;
    first_xfer_cyc = -1; last_read_cyc = -1;
    build_expected(v);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (v.busy_start) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    #2;
    t = 0;
    while (!done && t < 20000) begin
      @(negedge clk); #2; t++;
    end
    done_cyc = cyc;
    chk(done, $sformatf("v%0d_done", idx), 64'(done), 64'(1));
    chk(read_count == 32'(v.exp_reads), $sformatf("v%0d_read_count", idx), 64'(read_count), 64'(v.exp_reads));
    chk(error_count == 32'(v.exp_errs), $sformatf("v%0d_error_count", idx), 64'(error_count), 64'(v.exp_errs));
    chk(timeout == v.exp_to, $sformatf("v%0d_timeout", idx), 64'(timeout), 64'(v.exp_to));
    chk(first_err_row == 16'(v.exp_frow), $sformatf("v%0d_first_err_row", idx), 64'(first_err_row), 64'(v.exp_frow));
    chk(first_err_col == 4'(v.exp_fcol), $sformatf("v%0d_first_err_col", idx), 64'(first_err_col), 64'(v.exp_fcol));
    chk(sb_q.size() == 0, $sformatf("v%0d_cmds_left", idx), 64'(sb_q.size()), 64'(0));
    chk(!valid, $sformatf("v%0d_valid_idle", idx), 64'(valid), 64'(0));
    if (v.drop)
      chk(done_cyc - last_read_cyc == TIMEOUT + 1, $sformatf("v%0d_timeout_delay", idx),
          64'(done_cyc - last_read_cyc), 64'(TIMEOUT + 1));
    else begin
      exp_lat = (v.exp_reads == 0) ? 0 : last_read_cyc - first_xfer_cyc;
      chk(latency == 32'(exp_lat), $sformatf("v%0d_latency", idx), 64'(latency), 64'(exp_lat));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk(!valid && command == '0 && write_data == '0, {tag, "_cmd"}, 64'(command), 64'(0));
    chk(!done && !timeout, {tag, "_done_timeout"}, 64'({done, timeout}), 64'(0));
    chk(error_count == 0 && read_count == 0, {tag, "_counts"}, {error_count, read_count}, 64'(0));
    chk(latency == 0, {tag, "_latency"}, 64'(latency), 64'(0));
    chk(first_err_row == 0 && first_err_col == 0, {tag, "_first_err"}, 64'({first_err_row, first_err_col}), 64'(0));
    chk(!backend_controller_ren, {tag, "_ren"}, 64'(backend_controller_ren), 64'(0));
  endtask

  initial begin
    // mode rb re rs cs seed period stall corrupt drop busy | reads errs to frow fcol
    vecs[0] = '{0, 0, 16, 1, 1, 32'h0,        0,  0, 0, 0, 0, 256, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 16, 1, 1, 32'h0,        0, 50, 0, 0, 1, 256, 0, 0, 0, 0};
    vecs[2] = '{0, 0,  8, 1, 1, 32'h0,        0,  0, 1, 0, 0, 128, 1, 0, 5, 3};
    vecs[3] = '{1, 2,  6, 2, 4, 32'hA5,       0,  0, 0, 0, 0,   8, 0, 0, 0, 0};
    vecs[4] = '{0, 0,  2, 1, 1, 32'h1234,    15,  0, 0, 0, 0,  32, 0, 0, 0, 0};
    vecs[5] = '{0, 0,  2, 1, 1, 32'h0,        0,  0, 0, 1, 0,  31, 0, 1, 0, 0};
    vecs[6] = '{0, 5,  5, 1, 1, 32'h0,        0,  0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[7] = '{1, 3, 10, 3, 5, 32'hDEADBEEF, 0, 30, 0, 0, 0,  12, 0, 0, 0, 0};

    power_on_rst_n = 1'b0; start = 1'b0; cfg_mode = 1'b0; cfg_row_begin = '0; cfg_row_end = '0;
    cfg_row_stride = 16'd1; cfg_col_stride = 4'd1; cfg_seed = '0; cfg_ren_period = '0;
    ba_cmd_pm = 1'b0; read_data_valid = 1'b0; read_data = '0;
    repeat (3) @(negedge clk);
    #2 check_all_zero("reset");
    @(negedge clk); power_on_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2 chk(backend_controller_ren, "idle_ren_period0", 64'(backend_controller_ren), 64'(1));

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // reset in the middle of the write phase
    cfg_mode = 1'b0; cfg_row_begin = '0; cfg_row_end = 17'd16; cfg_row_stride = 16'd1;
    cfg_col_stride = 4'd1; cfg_seed = '0; cfg_ren_period = '0; stall_pct = 0; drop = 0; corrupt = 0;
    build_expected(vecs[0]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    #2 chk(valid && command[CMD_W-1 -: 2] == OP_WRITE, "midrun_in_write", 64'(command), 64'(mk_cmd(OP_WRITE, 30)));
    power_on_rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    power_on_rst_n = 1'b1;
    sb_q.delete(); ret_q.delete();
    repeat (3) @(negedge clk);
    #2 chk(!valid && !done && read_count == 0, "post_reset_idle", 64'({valid, done}), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
